// File: rtl/ppfifo_data_sink_checker_if.sv
// ----------------------------------------------------------------------------
// ppfifo_data_sink_checker_if
//   Read side of a ping-pong FIFO buffer handshake.
//
//   rd_rdy   FIFO -> sink   a full buffer is ready to be claimed
//   rd_act   sink -> FIFO   buffer claimed / being drained
//   rd_size  FIFO -> sink   number of words in the ready buffer
//   rd_stb   sink -> FIFO   one-cycle consume strobe (rd_data is consumed)
//   rd_data  FIFO -> sink   current FIFO word
//
//   master: FIFO side, slave: sink side.
// ----------------------------------------------------------------------------
interface ppfifo_data_sink_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24
);
    logic                  rd_rdy;
    logic                  rd_act;
    logic [SIZE_WIDTH-1:0] rd_size;
    logic                  rd_stb;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output rd_rdy,
        output rd_size,
        output rd_data,
        input  rd_act,
        input  rd_stb
    );

    modport slave (
        input  rd_rdy,
        input  rd_size,
        input  rd_data,
        output rd_act,
        output rd_stb
    );
endinterface

// File: rtl/ppfifo_data_sink_checker.sv
// ----------------------------------------------------------------------------
// ppfifo_data_sink_checker
//   Ping-pong FIFO read-side sink. Claims each ready buffer, drains it with an
//   optional inter-word gap, and discards or checks the data against an
//   incrementing (mode 1) or constant (mode 2) pattern. Word, block and error
//   statistics plus a first-error capture are exposed for a register file.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_enable               allow claiming new buffers
//   i_mode                 0 discard, 1 incrementing, 2 constant, 3 discard
//   i_pattern              seed (mode 1) / constant (mode 2)
//   i_gap                  idle cycles inserted after each strobe
//   i_clear                clear statistics and reseed expected value
//   rd                     FIFO read handshake (slave modport)
//   o_busy                 a buffer is being drained
//   o_word_count           words consumed (wraps)
//   o_block_count          buffers completed (wraps)
//   o_err_count            mismatches (saturating)
//   o_err_flag             sticky first-mismatch flag
//   o_first_err_index      in-block index of first mismatch
//   o_first_err_data       actual word at first mismatch
//   o_first_err_expected   expected word at first mismatch
// ----------------------------------------------------------------------------
module ppfifo_data_sink_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_pattern,
    input  logic [7:0]            i_gap,
    input  logic                  i_clear,
    ppfifo_data_sink_checker_if.slave rd,
    output logic                  o_busy,
    output logic [31:0]           o_word_count,
    output logic [31:0]           o_block_count,
    output logic [ERR_WIDTH-1:0]  o_err_count,
    output logic                  o_err_flag,
    output logic [SIZE_WIDTH-1:0] o_first_err_index,
    output logic [DATA_WIDTH-1:0] o_first_err_data,
    output logic [DATA_WIDTH-1:0] o_first_err_expected
);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    typedef enum logic [1:0] {
        M_DISCARD  = 2'd0,
        M_INC      = 2'd1,
        M_CONST    = 2'd2,
        M_DISCARD3 = 2'd3
    } mode_t;

    // control registers
    state_t                r_state;
    logic                  r_act;
    logic                  r_stb;
    logic [SIZE_WIDTH-1:0] r_count;
    logic [SIZE_WIDTH-1:0] r_size;
    mode_t                 r_mode;
    logic [7:0]            r_gap;

    // statistics registers
    logic [DATA_WIDTH-1:0] r_exp;
    logic [31:0]           r_word_count;
    logic [31:0]           r_block_count;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic                  r_err_flag;
    logic [SIZE_WIDTH-1:0] r_fe_index;
    logic [DATA_WIDTH-1:0] r_fe_data;
    logic [DATA_WIDTH-1:0] r_fe_expected;

    // next-state values
    state_t                w_state_nxt;
    logic                  w_act_nxt;
    logic                  w_stb_nxt;
    logic [SIZE_WIDTH-1:0] w_count_nxt;
    logic [SIZE_WIDTH-1:0] w_size_nxt;
    mode_t                 w_mode_nxt;
    logic [7:0]            w_gap_nxt;
    logic                  w_block_done;

    logic [DATA_WIDTH-1:0] w_exp_nxt;
    logic [31:0]           w_word_count_nxt;
    logic [31:0]           w_block_count_nxt;
    logic [ERR_WIDTH-1:0]  w_err_count_nxt;
    logic                  w_err_flag_nxt;
    logic [SIZE_WIDTH-1:0] w_fe_index_nxt;
    logic [DATA_WIDTH-1:0] w_fe_data_nxt;
    logic [DATA_WIDTH-1:0] w_fe_expected_nxt;

    logic                  w_compare;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;

    // ------------------------------------------------------------------
    // Control: claim, strobe pacing, block end
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_act_nxt    = r_act;
        w_stb_nxt    = 1'b0;
        w_count_nxt  = r_count;
        w_size_nxt   = r_size;
        w_mode_nxt   = r_mode;
        // gap counter runs down whenever no strobe is issued, so leftover
        // gap after the last word of a block also elapses while idle
        w_gap_nxt    = (r_gap != '0) ? r_gap - 8'd1 : r_gap;
        w_block_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_enable && rd.rd_rdy && !r_act) begin
                    w_act_nxt   = 1'b1;
                    w_count_nxt = '0;
                    w_size_nxt  = rd.rd_size;
                    w_mode_nxt  = mode_t'(i_mode);
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if ((r_count < r_size) && (r_gap == '0)) begin
                    w_stb_nxt   = 1'b1;
                    w_count_nxt = r_count + SIZE_WIDTH'(1);
                    w_gap_nxt   = i_gap;
                end else if ((r_count == r_size) && !r_stb) begin
                    // last strobe has been seen by the FIFO; release buffer
                    w_act_nxt    = 1'b0;
                    w_block_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data check and statistics
    // ------------------------------------------------------------------
    always_comb begin
        w_compare  = r_stb && ((r_mode == M_INC) || (r_mode == M_CONST));
        w_expected = (r_mode == M_INC) ? r_exp : i_pattern;
        w_mismatch = w_compare && (rd.rd_data != w_expected);
    end

    always_comb begin
        w_exp_nxt          = r_exp;
        w_word_count_nxt   = r_word_count;
        w_block_count_nxt  = r_block_count;
        w_err_count_nxt    = r_err_count;
        w_err_flag_nxt     = r_err_flag;
        w_fe_index_nxt     = r_fe_index;
        w_fe_data_nxt      = r_fe_data;
        w_fe_expected_nxt  = r_fe_expected;

        if (i_clear) begin
            // clear takes priority over any compare or block end this cycle
            w_exp_nxt         = i_pattern;
            w_word_count_nxt  = '0;
            w_block_count_nxt = '0;
            w_err_count_nxt   = '0;
            w_err_flag_nxt    = 1'b0;
            w_fe_index_nxt    = '0;
            w_fe_data_nxt     = '0;
            w_fe_expected_nxt = '0;
        end else begin
            if (r_stb) begin
                w_word_count_nxt = r_word_count + 32'd1;
            end
            if (w_compare && (r_mode == M_INC)) begin
                // no resync: expected advances on mismatches too
                w_exp_nxt = r_exp + DATA_WIDTH'(1);
            end
            if (w_mismatch) begin
                if (r_err_count != '1) begin
                    w_err_count_nxt = r_err_count + ERR_WIDTH'(1);
                end
                if (!r_err_flag) begin
                    // r_count was advanced when this word's strobe was issued
                    w_fe_index_nxt    = r_count - SIZE_WIDTH'(1);
                    w_fe_data_nxt     = rd.rd_data;
                    w_fe_expected_nxt = w_expected;
                    w_err_flag_nxt    = 1'b1;
                end
            end
            if (w_block_done) begin
                w_block_count_nxt = r_block_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_act         <= 1'b0;
            r_stb         <= 1'b0;
            r_count       <= '0;
            r_size        <= '0;
            r_mode        <= M_DISCARD;
            r_gap         <= '0;
            r_exp         <= '0;
            r_word_count  <= '0;
            r_block_count <= '0;
            r_err_count   <= '0;
            r_err_flag    <= 1'b0;
            r_fe_index    <= '0;
            r_fe_data     <= '0;
            r_fe_expected <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_act         <= w_act_nxt;
            r_stb         <= w_stb_nxt;
            r_count       <= w_count_nxt;
            r_size        <= w_size_nxt;
            r_mode        <= w_mode_nxt;
            r_gap         <= w_gap_nxt;
            r_exp         <= w_exp_nxt;
            r_word_count  <= w_word_count_nxt;
            r_block_count <= w_block_count_nxt;
            r_err_count   <= w_err_count_nxt;
            r_err_flag    <= w_err_flag_nxt;
            r_fe_index    <= w_fe_index_nxt;
            r_fe_data     <= w_fe_data_nxt;
            r_fe_expected <= w_fe_expected_nxt;
        end
    end

    assign rd.rd_act            = r_act;
    assign rd.rd_stb            = r_stb;
    assign o_busy               = (r_state == S_READ);
    assign o_word_count         = r_word_count;
    assign o_block_count        = r_block_count;
    assign o_err_count          = r_err_count;
    assign o_err_flag           = r_err_flag;
    assign o_first_err_index    = r_fe_index;
    assign o_first_err_data     = r_fe_data;
    assign o_first_err_expected = r_fe_expected;

endmodule

// File: tb/tb_ppfifo_data_sink_checker.sv
// ----------------------------------------------------------------------------
// tb_ppfifo_data_sink_checker
//   Directed and randomized bench for ppfifo_data_sink_checker. Expected
//   strobe/act timing is computed from the block schedule (claim edge, size,
//   gap); expected statistics come from a per-word scoreboard model.
// ----------------------------------------------------------------------------
module tb_ppfifo_data_sink_checker;

    localparam int DW = 32;
    localparam int SW = 8;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_pattern;
    logic [7:0]    i_gap;
    logic          i_clear;
    logic          o_busy;
    logic [31:0]   o_word_count;
    logic [31:0]   o_block_count;
    logic [EW-1:0] o_err_count;
    logic          o_err_flag;
    logic [SW-1:0] o_first_err_index;
    logic [DW-1:0] o_first_err_data;
    logic [DW-1:0] o_first_err_expected;

    ppfifo_data_sink_checker_if #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) rd_if ();

    ppfifo_data_sink_checker #(
        .DATA_WIDTH(DW),
        .SIZE_WIDTH(SW),
        .ERR_WIDTH (EW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_enable            (i_enable),
        .i_mode              (i_mode),
        .i_pattern           (i_pattern),
        .i_gap               (i_gap),
        .i_clear             (i_clear),
        .rd                  (rd_if.slave),
        .o_busy              (o_busy),
        .o_word_count        (o_word_count),
        .o_block_count       (o_block_count),
        .o_err_count         (o_err_count),
        .o_err_flag          (o_err_flag),
        .o_first_err_index   (o_first_err_index),
        .o_first_err_data    (o_first_err_data),
        .o_first_err_expected(o_first_err_expected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard model
    int unsigned   m_words;
    int unsigned   m_blocks;
    int unsigned   m_err;
    bit            m_flag;
    int unsigned   m_fe_idx;
    logic [DW-1:0] m_fe_data;
    logic [DW-1:0] m_fe_exp;
    logic [DW-1:0] m_exp;
    int            cur_mode;
    logic [DW-1:0] blk_words [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_words = 0; m_blocks = 0; m_err = 0; m_flag = 0;
        m_fe_idx = 0; m_fe_data = '0; m_fe_exp = '0; m_exp = '0;
    endtask

    task automatic model_clear();
        m_words = 0; m_blocks = 0; m_err = 0; m_flag = 0;
        m_fe_idx = 0; m_fe_data = '0; m_fe_exp = '0; m_exp = i_pattern;
    endtask

    // effect of one clock edge on the statistics
    task automatic model_edge(input bit clr, input bit word, input int idx, input bit blk_end);
        logic [DW-1:0] exp;
        logic [DW-1:0] data;
        if (clr) begin
            model_clear();
        end else begin
            if (word) begin
                m_words++;
                if (cur_mode == 1 || cur_mode == 2) begin
                    data = blk_words[idx];
                    exp  = (cur_mode == 1) ? m_exp : i_pattern;
                    if (cur_mode == 1) m_exp = m_exp + 1;
                    if (data != exp) begin
                        if (m_err < (1 << EW) - 1) m_err++;
                        if (!m_flag) begin
                            m_flag = 1; m_fe_idx = idx; m_fe_data = data; m_fe_exp = exp;
                        end
                    end
                end
            end
            if (blk_end) m_blocks++;
        end
    endtask

    function automatic bit stb_at(input int k, input int n, input int g);
        return (k >= 1) && (((k - 1) % (g + 1)) == 0) && (((k - 1) / (g + 1)) < n);
    endfunction

    function automatic int act_len(input int n, input int g);
        return (n == 0) ? 1 : (n - 1) * (g + 1) + 3;
    endfunction

    task automatic check_stats(input string tag);
        chk({tag, "_words"},  64'(o_word_count),         64'(32'(m_words)));
        chk({tag, "_blocks"}, 64'(o_block_count),        64'(32'(m_blocks)));
        chk({tag, "_err"},    64'(o_err_count),          64'(EW'(m_err)));
        chk({tag, "_flag"},   64'(o_err_flag),           64'(m_flag));
        chk({tag, "_feidx"},  64'(o_first_err_index),    64'(SW'(m_fe_idx)));
        chk({tag, "_fedat"},  64'(o_first_err_data),     64'(m_fe_data));
        chk({tag, "_feexp"},  64'(o_first_err_expected), 64'(m_fe_exp));
    endtask

    // One buffer: claim edge is k=0; i_clear is sampled at edge clear_k (<0: none)
    task automatic run_block(input string tag, input int n, input int g, input int mode, input int clear_k);
        int al;
        al = act_len(n, g);
        cur_mode = mode;
        @(negedge clk);
        i_mode        = 2'(mode);
        i_gap         = 8'(g);
        rd_if.rd_size = SW'(n);
        rd_if.rd_rdy  = 1'b1;
        i_enable      = 1'b1;
        i_clear       = 1'b0;
        for (int k = 0; k <= al; k++) begin
            @(posedge clk);
            model_edge(i_clear, (k >= 1) && stb_at(k - 1, n, g), (k >= 1) ? (k - 2) / (g + 1) + 0 : 0, k == al);
            @(negedge clk);
            chk({tag, "_act"},  64'(rd_if.rd_act), 64'(k < al));
            chk({tag, "_stb"},  64'(rd_if.rd_stb), 64'(stb_at(k, n, g)));
            chk({tag, "_busy"}, 64'(o_busy),       64'(k < al));
            if (k == 0) rd_if.rd_rdy = 1'b0;
            rd_if.rd_data = stb_at(k, n, g) ? blk_words[(k - 1) / (g + 1)] : $urandom;
            i_clear = (k + 1 == clear_k);
        end
        i_clear = 1'b0;
        repeat (g + 2) @(negedge clk);
        check_stats(tag);
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    initial begin
        int n, g, mode, al, ck;
        logic [DW-1:0] base;

        rst = 1'b1; i_enable = 1'b0; i_mode = '0; i_pattern = '0; i_gap = '0; i_clear = 1'b0;
        rd_if.rd_rdy = 1'b0; rd_if.rd_size = '0; rd_if.rd_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_act", 64'(rd_if.rd_act), 64'(0));
        chk("rst_stb", 64'(rd_if.rd_stb), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        check_stats("rst");
        rst = 1'b0;

        // mode 0, size 4, gap 0
        blk_words.delete();
        for (int i = 0; i < 4; i++) blk_words.push_back($urandom);
        run_block("m0", 4, 0, 0, -1);
        chk("m0_wc4", 64'(o_word_count), 64'(4));

        // mode 1, two clean 3-word blocks
        i_pattern = 32'h10;
        do_clear();
        blk_words = '{32'h10, 32'h11, 32'h12};
        run_block("m1a", 3, 0, 1, -1);
        blk_words = '{32'h13, 32'h14, 32'h15};
        run_block("m1b", 3, 0, 1, -1);
        chk("m1_blk2", 64'(o_block_count), 64'(2));

        // mode 1 with one mismatch, then a later mismatch
        do_clear();
        blk_words = '{32'h10, 32'h11, 32'h99, 32'h13};
        run_block("m1e", 4, 0, 1, -1);
        chk("m1e_idx", 64'(o_first_err_index), 64'(2));
        chk("m1e_dat", 64'(o_first_err_data), 64'h99);
        chk("m1e_exp", 64'(o_first_err_expected), 64'h12);
        blk_words = '{32'h14, 32'h77};
        run_block("m1f", 2, 0, 1, -1);
        chk("m1f_err", 64'(o_err_count), 64'(2));
        chk("m1f_idx", 64'(o_first_err_index), 64'(2));

        // mode 2, gap 3
        i_pattern = 32'hA5A5A5A5;
        blk_words = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        run_block("m2", 3, 3, 2, -1);

        // size 0 then enable low
        do_clear();
        blk_words.delete();
        run_block("sz0", 0, 0, 0, -1);
        chk("sz0_blk", 64'(o_block_count), 64'(1));
        i_enable = 1'b0;
        rd_if.rd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("en0_act", 64'(rd_if.rd_act), 64'(0));
        end
        rd_if.rd_rdy = 1'b0;

        // reset mid-block after 2 strobes of 8
        @(negedge clk);
        i_mode = 2'd0; i_gap = 8'd0; rd_if.rd_size = 8'd8; rd_if.rd_rdy = 1'b1; i_enable = 1'b1;
        @(negedge clk);
        rd_if.rd_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_stb", 64'(rd_if.rd_stb), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk("mrst_act", 64'(rd_if.rd_act), 64'(0));
        chk("mrst_stb", 64'(rd_if.rd_stb), 64'(0));
        check_stats("mrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // clear coincident with a mismatch (word compared at edge 2)
        i_pattern = 32'h0F0F_0F0F;
        blk_words = '{32'hDEAD_BEEF};
        run_block("clrmm", 1, 0, 2, 2);
        chk("clrmm_err", 64'(o_err_count), 64'(0));

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            mode = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 6));
            g    = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) i_pattern = $urandom;
            al   = act_len(n, g);
            ck   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, al)) : -1;
            base = (mode == 1) ? m_exp : i_pattern;
            blk_words.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) blk_words.push_back($urandom);
                else if (mode == 1) blk_words.push_back(base + DW'(i));
                else blk_words.push_back(base);
            end
            run_block("rnd", n, g, mode, ck);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppfifo_data_sink_checker.md
Name: ppfifo_data_sink_checker

Overview:
Parametrised ping-pong FIFO read-side sink for DMA/loopback benches and bring-up images. It claims each ready buffer, drains it with an optional programmable inter-word gap, and either discards the data or checks it against an incrementing or constant pattern. Word, block and error statistics, plus a first-error capture, are exposed for a register file.

Parameters:
DATA_WIDTH, 32, FIFO data word width
SIZE_WIDTH, 24, width of buffer size and word index
ERR_WIDTH, 16, error counter width (saturating)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
i_enable  in  1  allow claiming new buffers
i_mode  in  2  0 discard, 1 incrementing check, 2 constant check, 3 treated as discard
i_pattern  in  DATA_WIDTH  seed (mode 1) / constant (mode 2)
i_gap  in  8  idle cycles inserted after each strobe
i_clear  in  1  pulse: clear statistics, reseed expected
i_rd_rdy  in  1  FIFO buffer ready
o_rd_act  out  1  buffer claimed
i_rd_size  in  SIZE_WIDTH  words in ready buffer
o_rd_stb  out  1  one-cycle consume strobe
i_rd_data  in  DATA_WIDTH  current FIFO word
o_busy  out  1  state != IDLE
o_word_count  out  32  total words consumed (wraps)
o_block_count  out  32  total buffers completed (wraps)
o_err_count  out  ERR_WIDTH  mismatches, saturates at all-ones
o_err_flag  out  1  sticky, set on first mismatch
o_first_err_index  out  SIZE_WIDTH  in-block index of first mismatch
o_first_err_data  out  DATA_WIDTH  actual word at first mismatch
o_first_err_expected  out  DATA_WIDTH  expected word at first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, expected register 0, gap counter 0. Reset mid-block drops o_rd_act on the next edge; no block counted.
- All outputs registered. States IDLE, READ.
- IDLE: if i_enable && i_rd_rdy && !o_rd_act: o_rd_act<=1, r_count<=0, latch i_rd_size into r_size, latch i_mode into r_mode, go READ. i_enable low never interrupts a block in progress.
- READ: if r_count<r_size and gap counter==0: o_rd_stb<=1 next cycle, r_count++, gap counter<=i_gap; else o_rd_stb<=0 and gap counter decrements if nonzero.
- Block end: in READ with r_count==r_size and o_rd_stb==0: o_rd_act<=0, o_block_count++, go IDLE. The next claim needs o_rd_act low for at least one cycle.
- Timing, gap 0, size N: act rises 1 cycle after rdy sampled; stb high N consecutive cycles starting 1 cycle after act; act falls 1 cycle after the last stb.
- Size 0: act high exactly 1 cycle, no strobes, block counted.
- Compare: on every cycle with o_rd_stb==1, i_rd_data is the consumed word. o_word_count++.
- Mode 1: expected=r_exp; r_exp increments mod 2^DATA_WIDTH after every compared word, including mismatches (no resync). r_exp persists across blocks.
- Mode 2: expected=i_pattern, sampled live.
- Mode 0/3: no compare, no errors.
- Mismatch: o_err_count++ (saturate). If o_err_flag==0, capture index (r_count-1 of that word), data and expected, then set o_err_flag.
- i_clear: zeroes word/block/err counts, flag and capture registers; r_exp<=i_pattern. Clear wins over a same-cycle compare or block end; that compare or block end is not counted. Clear does not affect o_rd_act, o_rd_stb, r_count or state.
- i_gap is sampled each time a strobe is issued; changing it mid-block affects subsequent gaps only.

Test Plan:
- Mode 0, i_rd_size=4, gap 0, rdy held high -> act high 6 cycles, stb high 4 consecutive cycles, word_count=4, block_count=1, err_count=0.
- Mode 1, pattern 0x10 + clear, two 3-word blocks of data 0x10..0x15 -> err_count=0, err_flag=0, block_count=2.
- Mode 1, data 0x10,0x11,0x99,0x13 -> err_count=1, first_err_index=2, first_err_data=0x99, first_err_expected=0x12; later mismatches leave capture unchanged.
- Mode 2, pattern 0xA5A5A5A5, gap=3, size 3 -> strobes spaced 4 cycles apart, act high 11 cycles, no errors.
- Size 0 buffer, then i_enable low with rdy high -> one 1-cycle act, block_count=1, then no further claims.
- Reset asserted mid-block after 2 strobes of 8 -> next cycle act=0, stb=0, all counts 0; i_clear coincident with a mismatch -> err_count stays 0.
